rr_read_switch: RTL

// - Next-generation read crossbar between NB_RDAGENT read agents and NB_WRAGENT BRAM banks.
// - Generalises the read switch to any agent count, with a fair round-robin arbiter per bank.
// - Colliding agents are stalled with a ready handshake instead of being served silently.
// - Returns data and collision flags after a parametrised bank latency, with m_rdvalid.

---
 rtl/rr_read_switch_pkg.sv | 24 ++
 rtl/rr_read_switch_arbiter.sv | 46 ++++
 rtl/rr_read_switch.sv | 111 +++++++++++
 3 files changed

// File: rtl/rr_read_switch_pkg.sv
// Shared sizing helpers and pipeline types for the round-robin BRAM read crossbar.
package meduram_pkg;

  localparam int unsigned MAX_ID_W   = 16;
  localparam int unsigned MAX_BANK_W = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sel_width(input int unsigned nb_wr, input int unsigned wrcol);
    return idx_width(nb_wr) + ((wrcol != 0) ? 1 : 0);
  endfunction

  typedef logic [MAX_ID_W-1:0] agent_id_t;

  typedef struct packed {
    logic                  valid;
    logic [MAX_BANK_W-1:0] bank;
    logic                  wrcol;
    logic                  stalled;
  } rd_stage_t;

endpackage

// File: rtl/rr_read_switch_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and winner id, pointer advances past each winner.
module rr_arbiter
  import meduram_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         granted,
  output agent_id_t    winner
);

  localparam int unsigned IW = idx_width(N);
  localparam int unsigned CW = IW + 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [CW-1:0] cand;

  // Search order starts at ptr and wraps modulo N (N need not be a power of two).
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!granted && req[cand[IW-1:0]]) begin
        granted = 1'b1;
        win     = cand[IW-1:0];
      end
    end
    if (granted) grant[win] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ptr <= '0;
    else if (granted) ptr <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
  end

  assign winner = agent_id_t'(win);

endmodule

// File: rtl/rr_read_switch.sv
// Read crossbar: NB_RDAGENT agents share NB_WRAGENT BRAM banks through per-bank
// round-robin arbiters; granted reads return RD_LATENCY+1 cycles later with collision flags.
module rr_read_switch
  import meduram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned NB_WRAGENT      = 2,
  parameter int unsigned NB_RDAGENT      = 4,
  parameter int unsigned WRITE_COLLISION = 1,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned SELECT_WIDTH    = sel_width(NB_WRAGENT, WRITE_COLLISION)
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  output logic [NB_WRAGENT-1:0]              s_rden,
  output logic [NB_WRAGENT*ADDR_WIDTH-1:0]   s_rdaddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0]   s_rddata,
  input  logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
  input  logic [NB_RDAGENT-1:0]              m_rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
  output logic [NB_RDAGENT-1:0]              m_rdready,
  output logic [NB_RDAGENT-1:0]              m_rdvalid,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0]   m_rddata,
  output logic [NB_RDAGENT*2-1:0]            m_rdcollision
);

  localparam int unsigned IDXW = idx_width(NB_WRAGENT);

  logic [IDXW-1:0]       bank_idx  [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] wrcol;
  logic [NB_RDAGENT-1:0] waited;
  logic [NB_RDAGENT-1:0] req       [NB_WRAGENT];
  logic [NB_RDAGENT-1:0] grant     [NB_WRAGENT];
  agent_id_t             winner    [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] bank_data [NB_WRAGENT];
  rd_stage_t             pipe      [NB_RDAGENT][RD_LATENCY];
  rd_stage_t             tail      [NB_RDAGENT];

  // Requests are masked while in reset so no agent sees a grant.
  always_comb begin
    for (int unsigned b = 0; b < NB_WRAGENT; b++) req[b] = '0;
    for (int unsigned i = 0; i < NB_RDAGENT; i++) begin
      bank_idx[i] = bank_select[i*SELECT_WIDTH +: IDXW];
      wrcol[i]    = (WRITE_COLLISION != 0) && bank_select[i*SELECT_WIDTH + SELECT_WIDTH - 1];
      for (int unsigned b = 0; b < NB_WRAGENT; b++)
        if (aresetn && m_rden[i] && (bank_idx[i] == IDXW'(b))) req[b][i] = 1'b1;
    end
  end

  for (genvar b = 0; b < NB_WRAGENT; b++) begin : g_bank
    rr_arbiter #(.N(NB_RDAGENT)) u_arb (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req     (req[b]),
      .grant   (grant[b]),
      .granted (s_rden[b]),
      .winner  (winner[b])
    );
    assign bank_data[b] = s_rddata[b*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    s_rdaddr  = '0;
    m_rdready = '0;
    for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
      if (s_rden[b])
        s_rdaddr[b*ADDR_WIDTH +: ADDR_WIDTH] = m_rdaddr[winner[b]*ADDR_WIDTH +: ADDR_WIDTH];
      m_rdready = m_rdready | grant[b];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NB_RDAGENT; i++) tail[i] = pipe[i][RD_LATENCY-1];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      waited        <= '0;
      m_rdvalid     <= '0;
      m_rddata      <= '0;
      m_rdcollision <= '0;
      for (int unsigned i = 0; i < NB_RDAGENT; i++)
        for (int unsigned s = 0; s < RD_LATENCY; s++) pipe[i][s] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_RDAGENT; i++) begin
        if (m_rden[i] && !m_rdready[i]) waited[i] <= 1'b1;
        else if (m_rdready[i])          waited[i] <= 1'b0;
        // A granted request is never stalled in its grant cycle, so the stall flag is just waited.
        pipe[i][0] <= '{valid:   m_rdready[i],
                        bank:    MAX_BANK_W'(bank_idx[i]),
                        wrcol:   wrcol[i],
                        stalled: waited[i]};
        for (int unsigned s = 1; s < RD_LATENCY; s++) pipe[i][s] <= pipe[i][s-1];
        m_rdvalid[i] <= tail[i].valid;
        if (tail[i].valid) begin
          m_rddata[i*DATA_WIDTH +: DATA_WIDTH] <= bank_data[tail[i].bank[IDXW-1:0]];
          m_rdcollision[i*2 +: 2]              <= {tail[i].stalled, tail[i].wrcol};
        end
      end
    end
  end

  if ((1 << IDXW) > NB_WRAGENT) begin : g_sel_chk
    for (genvar i = 0; i < NB_RDAGENT; i++) begin : g_agent
      a_sel_range: assert property (@(posedge aclk) disable iff (!aresetn)
        !(m_rden[i] && (bank_idx[i] >= IDXW'(NB_WRAGENT))));
    end
  end

endmodule
